gshare_pht: RTL
===============

GSHARE_PHT -- requirements
Module: gshare_pht

Interface
REQ-001 SHALL take parameter W_IND, default 6: table index width; the table holds 2**W_IND counters.
REQ-002 SHALL take parameter W_CTR, default 2: saturating counter width; legal range is W_CTR >= 2.
REQ-003 SHALL take parameter W_HIST, default 6: global history width; legal range is 1 <= W_HIST <= W_IND.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: global enable; when low, no request is accepted.
REQ-007 SHALL have port predict, input, 1 bit: prediction request.
REQ-008 SHALL have port pc_idx, input, W_IND bits: PC-derived index for the prediction request.
REQ-009 SHALL have port resolve, input, 1 bit: branch resolution (update) request.
REQ-010 SHALL have port res_idx, input, W_IND bits: table index to update, as returned earlier on pred_idx.
REQ-011 SHALL have port res_taken, input, 1 bit: actual branch outcome, 1 = taken.
REQ-012 SHALL have port res_mispred, input, 1 bit: the resolved branch was mispredicted.
REQ-013 SHALL have port ready, output, 1 bit: table initialised and accepting requests.
REQ-014 SHALL have port pred_valid, output, 1 bit: prediction result valid this cycle.
REQ-015 SHALL have port pred_taken, output, 1 bit: predicted direction.
REQ-016 SHALL have port pred_idx, output, W_IND bits: hashed table index used for the prediction.
REQ-017 SHALL have port ghr, output, W_HIST bits: current global history register.
REQ-018 SHALL have port mispred_cnt, output, 16 bits: saturating misprediction count.

Function
REQ-019 SHALL implement a 2-state FSM, INIT and RUN; reset forces INIT; ready = (state == RUN).
REQ-020 In INIT, SHALL write 2**(W_CTR-1)-1 (weakly not-taken) to one entry per cycle, addresses 0 to 2**W_IND-1, then enter RUN the next cycle; all requests in INIT are ignored.
REQ-021 SHALL accept a predict when en, ready and predict are all 1; hashed index = pc_idx XOR zero-extended ghr.
REQ-022 Accepted predict SHALL produce, on the next cycle only: pred_valid=1, pred_taken = MSB of counter[hashed index], pred_idx = hashed index.
REQ-023 When pred_valid=0, pred_taken and pred_idx SHALL be 0.
REQ-024 SHALL accept a resolve when en, ready and resolve are all 1.
REQ-025 Accepted resolve with res_taken=1 SHALL increment counter[res_idx], saturating at 2**W_CTR-1.
REQ-026 Accepted resolve with res_taken=0 SHALL decrement counter[res_idx], saturating at 0.
REQ-027 Accepted resolve SHALL shift ghr left by one, inserting res_taken at bit 0 and discarding the MSB.
REQ-028 Accepted resolve with res_mispred=1 SHALL increment mispred_cnt, holding at 16'hFFFF.
REQ-029 Simultaneous accepted predict and resolve SHALL both take effect in the same cycle.
REQ-030 A prediction in the same cycle as a resolve SHALL use the pre-update ghr and pre-update counter, including when the indices are equal (read-old).
REQ-031 When en=0, counters, ghr and mispred_cnt SHALL hold, and pred_valid SHALL be 0 on the next cycle.
REQ-032 The INIT sweep SHALL proceed regardless of en.

Reset
REQ-033 On rst=1, SHALL immediately drive: state INIT, init address 0, ready=0, pred_valid=0, pred_taken=0, pred_idx=0, ghr=0, mispred_cnt=0.
REQ-034 Reset asserted mid-INIT or mid-RUN SHALL abort all activity and restart the INIT sweep from address 0 after release.

Verification
REQ-035 Reset release, defaults -> ready=0 for 64 cycles then 1; predict pc_idx=0x2A -> next cycle pred_valid=1, pred_taken=0, pred_idx=0x2A.
REQ-036 Two resolves res_idx=5, taken -> ghr=6'b000011, counter[5]=3; predict pc_idx=6 -> pred_idx=5, pred_taken=1.
REQ-037 Five taken then four not-taken resolves on idx 9, checked with ghr forced to 0 by predicting pc_idx = 9 XOR ghr -> counter 3, 3, then 2, 1, 0, 0; pred_taken flips to 0 after the second not-taken.
REQ-038 Predict and resolve in the same cycle hitting the same index, counter 1, res_taken=1 -> pred_taken=0 (old value); a following predict at the same hashed index -> 1.
REQ-039 en=0 with predict and resolve held high for 3 cycles -> pred_valid stays 0; ghr, counters and mispred_cnt unchanged.
REQ-040 Three resolves with res_mispred=1 -> mispred_cnt=3; rst pulse mid-RUN -> all outputs 0 immediately and ready=0 for 64 cycles.

Source files
------------

// File: rtl/gshare_pht_if.sv
// Request/response bundle for the gshare pattern history table.
// The master side issues predictions and branch resolutions; the slave
// side (the table) returns the prediction, its readiness and its statistics.
interface gshare_pht_if #(
    parameter int W_IND  = 6,
    parameter int W_HIST = 6
);
    logic              en;
    logic              predict;
    logic [W_IND-1:0]  pc_idx;
    logic              resolve;
    logic [W_IND-1:0]  res_idx;
    logic              res_taken;
    logic              res_mispred;
    logic              ready;
    logic              pred_valid;
    logic              pred_taken;
    logic [W_IND-1:0]  pred_idx;
    logic [W_HIST-1:0] ghr;
    logic [15:0]       mispred_cnt;

    modport master (
        output en, predict, pc_idx, resolve, res_idx, res_taken, res_mispred,
        input  ready, pred_valid, pred_taken, pred_idx, ghr, mispred_cnt
    );

    modport slave (
        input  en, predict, pc_idx, resolve, res_idx, res_taken, res_mispred,
        output ready, pred_valid, pred_taken, pred_idx, ghr, mispred_cnt
    );
endinterface

// File: rtl/gshare_pht.sv
// Gshare branch predictor pattern history table.
// After reset the table is swept to "weakly not-taken" one entry per cycle;
// once running, predictions hash the PC index with the global history and
// resolutions train the addressed saturating counter and shift the history.
// A same-cycle prediction always sees the counter and history before update.
module gshare_pht #(
    parameter int W_IND  = 6,
    parameter int W_CTR  = 2,
    parameter int W_HIST = 6
) (
    input  logic        clk,
    input  logic        rst,
    gshare_pht_if.slave bus
);
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [W_CTR-1:0] CTR_INIT  = {1'b0, {(W_CTR-1){1'b1}}};
    localparam logic [W_CTR-1:0] CTR_MAX   = '1;
    localparam logic [W_IND-1:0] ADDR_LAST = '1;

    state_t            state;
    state_t            state_next;
    logic [W_IND-1:0]  init_addr;
    logic [W_CTR-1:0]  table_mem [2**W_IND];

    logic [W_HIST-1:0] ghr_q;
    logic [15:0]       mis_q;
    logic              pv_q;
    logic              pt_q;
    logic [W_IND-1:0]  pi_q;

    logic              pred_acc;
    logic              res_acc;
    logic [W_IND-1:0]  hash_idx;
    logic [W_CTR-1:0]  res_ctr;
    logic [W_CTR-1:0]  res_ctr_next;
    logic              wr_en;
    logic [W_IND-1:0]  wr_addr;
    logic [W_CTR-1:0]  wr_data;

    assign pred_acc = bus.en && bus.predict && (state == RUN);
    assign res_acc  = bus.en && bus.resolve && (state == RUN);
    assign hash_idx = bus.pc_idx ^ W_IND'(ghr_q);

    assign bus.ready       = (state == RUN);
    assign bus.pred_valid  = pv_q;
    assign bus.pred_taken  = pt_q;
    assign bus.pred_idx    = pi_q;
    assign bus.ghr         = ghr_q;
    assign bus.mispred_cnt = mis_q;

    // State register and init sweep address; reset restarts the sweep at 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            init_addr <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                init_addr <= init_addr + 1'b1;
            end
        end
    end

    // Leave INIT once the last entry has been written; RUN is terminal
    always_comb begin
        state_next = state;
        case (state)
            INIT: if (init_addr == ADDR_LAST) state_next = RUN;
            RUN:  state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    // Saturating training step for the counter addressed by the resolution
    always_comb begin
        res_ctr      = table_mem[bus.res_idx];
        res_ctr_next = res_ctr;
        if (bus.res_taken) begin
            if (res_ctr != CTR_MAX) res_ctr_next = res_ctr + 1'b1;
        end else begin
            if (res_ctr != '0) res_ctr_next = res_ctr - 1'b1;
        end
    end

    // Single write port shared by the init sweep and resolution training
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = init_addr;
        wr_data = CTR_INIT;
        if (state == INIT) begin
            wr_en = 1'b1;
        end else if (res_acc) begin
            wr_en   = 1'b1;
            wr_addr = bus.res_idx;
            wr_data = res_ctr_next;
        end
    end

    // Counter storage; contents are only meaningful after the init sweep
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_mem[wr_addr] <= wr_data;
        end
    end

    // Prediction result, history and misprediction statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q  <= 1'b0;
            pt_q  <= 1'b0;
            pi_q  <= '0;
            ghr_q <= '0;
            mis_q <= '0;
        end else begin
            pv_q <= pred_acc;
            pt_q <= pred_acc ? table_mem[hash_idx][W_CTR-1] : 1'b0;
            pi_q <= pred_acc ? hash_idx : '0;
            if (res_acc) begin
                ghr_q <= (ghr_q << 1) | W_HIST'(bus.res_taken);
                if (bus.res_mispred && (mis_q != 16'hFFFF)) begin
                    mis_q <= mis_q + 16'd1;
                end
            end
        end
    end
endmodule
